// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the drawing stages.
// The timing generator drives this bundle through the master modport.
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs,
        output line_start, frame_start, frame_count
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs,
        input line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator: counters, blank, delayed syncs,
// line/frame strobes and a frame counter for animation logic.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned SYNC_DELAY = 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  tim_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counters");
    end
    if (SYNC_DELAY > 4) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be 0..4");
    end

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       line_q, line_d;
    logic       frame_q, frame_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic       h_wrap, v_wrap;
    logic       hs_raw, vs_raw;

    assign h_wrap = (hc_q == H_LAST);
    assign v_wrap = (vc_q == V_LAST);

    always_comb begin
        hc_d    = hc_q + 10'd1;
        vc_d    = vc_q;
        line_d  = h_wrap;
        frame_d = h_wrap && v_wrap;
        fcnt_d  = fcnt_q;
        if (h_wrap) begin
            hc_d = '0;
            vc_d = v_wrap ? '0 : vc_q + 10'd1;
            if (v_wrap) fcnt_d = fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q    <= '0;
            vc_q    <= '0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // vs spans whole lines, so it depends on vc alone
    assign hs_raw = !((hc_q >= HS_BEG) && (hc_q < HS_END));
    assign vs_raw = !((vc_q >= VS_BEG) && (vc_q < VS_END));

    if (SYNC_DELAY == 0) begin : g_sync_comb
        assign tim_o.hs = hs_raw;
        assign tim_o.vs = vs_raw;
    end else begin : g_sync_pipe
        logic [SYNC_DELAY-1:0] hs_q, vs_q;
        logic [SYNC_DELAY:0]   hs_d, vs_d;

        assign hs_d = {hs_q, hs_raw};
        assign vs_d = {vs_q, vs_raw};

        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                hs_q <= '1;
                vs_q <= '1;
            end else begin
                hs_q <= hs_d[SYNC_DELAY-1:0];
                vs_q <= vs_d[SYNC_DELAY-1:0];
            end
        end

        assign tim_o.hs = hs_q[SYNC_DELAY-1];
        assign tim_o.vs = vs_q[SYNC_DELAY-1];
    end

    assign tim_o.DrawX       = hc_q;
    assign tim_o.DrawY       = vc_q;
    assign tim_o.blank       = reset_n && (hc_q < H_VIS) && (vc_q < V_VIS);
    assign tim_o.line_start  = line_q;
    assign tim_o.frame_start = frame_q;
    assign tim_o.frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size generator for line timing, small-raster
// instances for frame timing, sync delay variants and frame counter wrap.
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   bcnt;

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen_if if_d ();
    vga_timing_gen_if if_s0 ();
    vga_timing_gen_if if_s1 ();
    vga_timing_gen_if if_s3 ();

    vga_timing_gen u_def (.vga_clk(vga_clk), .reset_n(reset_n), .tim_o(if_d));

    // small raster: 16 clocks/line, 10 lines/frame, hs raw low hc 10..12,
    // vs raw low vc 7..8, visible 8x6
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(0)
    ) u_s0 (.vga_clk(vga_clk), .reset_n(reset_n), .tim_o(if_s0));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(1)
    ) u_s1 (.vga_clk(vga_clk), .reset_n(reset_n), .tim_o(if_s1));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(3)
    ) u_s3 (.vga_clk(vga_clk), .reset_n(reset_n), .tim_o(if_s3));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge vga_clk);
        cyc++;
    endtask

    task automatic go_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, " def X"},  32'(if_d.DrawX), 0);
        check({tag, " def Y"},  32'(if_d.DrawY), 0);
        check({tag, " def hs"}, 32'(if_d.hs), 1);
        check({tag, " def vs"}, 32'(if_d.vs), 1);
        check({tag, " def blank"}, 32'(if_d.blank), 0);
        check({tag, " def ls"}, 32'(if_d.line_start), 0);
        check({tag, " def fs"}, 32'(if_d.frame_start), 0);
        check({tag, " def fc"}, 32'(if_d.frame_count), 0);
        check({tag, " s1 hs"},  32'(if_s1.hs), 1);
        check({tag, " s3 hs"},  32'(if_s3.hs), 1);
        check({tag, " s1 fc"},  32'(if_s1.frame_count), 0);
        check({tag, " s1 blank"}, 32'(if_s1.blank), 0);
    endtask

    initial begin
        repeat (3) @(negedge vga_clk);
        check_reset("rst");
        reset_n = 1'b1;
        cyc = 0;

        go_to(1);
        check("def X after release", 32'(if_d.DrawX), 1);
        check("def blank visible", 32'(if_d.blank), 1);

        go_to(9);
        check("s0 hs hc9", 32'(if_s0.hs), 1);
        go_to(10);
        check("s0 hs hc10", 32'(if_s0.hs), 0);
        check("s1 hs hc10", 32'(if_s1.hs), 1);
        check("s3 hs hc10", 32'(if_s3.hs), 1);
        check("s3 X hc10", 32'(if_s3.DrawX), 10);
        go_to(11);
        check("s1 hs hc11", 32'(if_s1.hs), 0);
        go_to(12);
        check("s3 hs hc12", 32'(if_s3.hs), 1);
        go_to(13);
        check("s3 hs hc13", 32'(if_s3.hs), 0);
        check("s1 hs hc13", 32'(if_s1.hs), 0);
        check("s0 hs hc13", 32'(if_s0.hs), 1);
        go_to(14);
        check("s1 hs hc14", 32'(if_s1.hs), 1);
        go_to(15);
        check("s3 hs hc15", 32'(if_s3.hs), 0);
        go_to(16);
        check("s3 hs hc0", 32'(if_s3.hs), 1);
        check("s1 X wrap", 32'(if_s1.DrawX), 0);
        check("s1 Y line1", 32'(if_s1.DrawY), 1);
        check("s1 ls line1", 32'(if_s1.line_start), 1);
        check("s1 fs line1", 32'(if_s1.frame_start), 0);
        go_to(17);
        check("s1 ls off", 32'(if_s1.line_start), 0);

        go_to(87);
        check("s1 blank (7,5)", 32'(if_s1.blank), 1);
        go_to(95);
        check("s1 blank (15,5)", 32'(if_s1.blank), 0);
        go_to(96);
        check("s1 blank (0,6)", 32'(if_s1.blank), 0);
        check("s1 Y line6", 32'(if_s1.DrawY), 6);

        go_to(112);
        check("s1 vs (0,7)", 32'(if_s1.vs), 1);
        check("s0 vs (0,7)", 32'(if_s0.vs), 0);
        go_to(113);
        check("s1 vs (1,7)", 32'(if_s1.vs), 0);
        go_to(144);
        check("s1 vs (0,9)", 32'(if_s1.vs), 0);
        check("s0 vs (0,9)", 32'(if_s0.vs), 1);
        go_to(145);
        check("s1 vs (1,9)", 32'(if_s1.vs), 1);

        go_to(159);
        check("s1 X end", 32'(if_s1.DrawX), 15);
        check("s1 Y end", 32'(if_s1.DrawY), 9);
        check("s1 fs before", 32'(if_s1.frame_start), 0);
        check("s1 fc before", 32'(if_s1.frame_count), 0);
        go_to(160);
        check("s1 fs frame1", 32'(if_s1.frame_start), 1);
        check("s1 ls frame1", 32'(if_s1.line_start), 1);
        check("s1 fc frame1", 32'(if_s1.frame_count), 1);
        check("s1 Y frame1", 32'(if_s1.DrawY), 0);

        bcnt = 0;
        for (int i = 0; i < 160; i++) begin
            bcnt += int'(if_s1.blank);
            if (i == 1) check("s1 fs pulse width", 32'(if_s1.frame_start), 0);
            tick();
        end
        check("s1 blank per frame", 32'(bcnt), 48);

        go_to(639);
        check("def blank x639", 32'(if_d.blank), 1);
        go_to(640);
        check("def blank x640", 32'(if_d.blank), 0);
        go_to(656);
        check("def hs x656", 32'(if_d.hs), 1);
        go_to(657);
        check("def hs x657", 32'(if_d.hs), 0);
        go_to(752);
        check("def hs x752", 32'(if_d.hs), 0);
        go_to(753);
        check("def hs x753", 32'(if_d.hs), 1);
        go_to(800);
        check("def X wrap", 32'(if_d.DrawX), 0);
        check("def Y line1", 32'(if_d.DrawY), 1);
        check("def ls line1", 32'(if_d.line_start), 1);
        check("def fs line1", 32'(if_d.frame_start), 0);
        go_to(801);
        check("def ls off", 32'(if_d.line_start), 0);
        go_to(1456);
        check("def hs line1 x656", 32'(if_d.hs), 1);
        go_to(1457);
        check("def hs line1 x657", 32'(if_d.hs), 0);

        go_to(40800);
        check("s1 fc 255", 32'(if_s1.frame_count), 255);
        check("s1 fs 255", 32'(if_s1.frame_start), 1);
        go_to(40960);
        check("s1 fc wrap", 32'(if_s1.frame_count), 0);
        check("s1 fs wrap", 32'(if_s1.frame_start), 1);
        check("def X 40960", 32'(if_d.DrawX), 160);
        check("def Y 40960", 32'(if_d.DrawY), 51);
        check("def fc no frame", 32'(if_d.frame_count), 0);

        go_to(41500);
        check("def X pre-rst", 32'(if_d.DrawX), 700);
        check("def hs pre-rst", 32'(if_d.hs), 0);
        check("s1 hs pre-rst", 32'(if_s1.hs), 0);
        reset_n = 1'b0;
        #1;
        check_reset("midrst");

        @(negedge vga_clk);
        reset_n = 1'b1;
        cyc = 0;
        tick();
        check("def X after rerelease", 32'(if_d.DrawX), 1);
        check("def Y after rerelease", 32'(if_d.DrawY), 0);
        check("s1 X after rerelease", 32'(if_s1.DrawX), 1);
        check("def blank after rerelease", 32'(if_d.blank), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
